// File: rtl/obl_tree_engine.sv
// Oblique decision-tree inference engine.
// Each node holds a coefficient vector, a threshold and two child pointers.
// A traversal runs a serial MAC per node (one feature per cycle) and then
// follows the left or right pointer until it reaches a leaf or the depth limit.
module obl_tree_engine #(
    parameter int N_FEAT    = 5,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int MAX_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [N_FEAT*DATA_W-1:0]   cfg_coef,
    input  logic [DATA_W-1:0]          cfg_thr,
    input  logic [2*(ADDR_W+1)-1:0]    cfg_child,
    input  logic [N_FEAT*DATA_W-1:0]   feat_in,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          class_out,
    output logic                       err,
    output logic [7:0]                 path_len
);
    localparam int FW    = N_FEAT * DATA_W;
    localparam int PW    = ADDR_W + 1;
    localparam int NW    = FW + DATA_W + 2 * PW;
    localparam int ACC_W = 2 * DATA_W + $clog2(N_FEAT) + 1;
    localparam int KW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_CMP, S_DONE} state_t;

    // Node word layout: {coefficients, threshold, left_ptr, right_ptr}
    logic [NW-1:0]             r_mem [DEPTH];
    logic [NW-1:0]             r_node;
    logic [FW-1:0]             r_feat;
    logic [ADDR_W-1:0]         r_addr;
    logic signed [ACC_W-1:0]   r_acc;
    logic [KW-1:0]             r_k;
    logic [7:0]                r_cnt;
    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic [ADDR_W-1:0]         r_class;
    logic [7:0]                r_path_len;
    logic                      r_res_err;
    logic [ADDR_W-1:0]         r_res_class;

    logic signed [DATA_W-1:0]  w_feat_k;
    logic signed [DATA_W-1:0]  w_coef_k;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_thr_ext;
    logic [PW-1:0]             w_left;
    logic [PW-1:0]             w_right;
    logic [PW-1:0]             w_sel;
    logic [7:0]                w_cnt_nxt;

    // Exact signed product of two DATA_W operands, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] a_w;
        logic signed [2*DATA_W-1:0] b_w;
        logic signed [2*DATA_W-1:0] p;
        a_w = {{DATA_W{a[DATA_W-1]}}, a};
        b_w = {{DATA_W{b[DATA_W-1]}}, b};
        p   = a_w * b_w;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_out = r_class;
    assign err       = r_err;
    assign path_len  = r_path_len;

    // Operand selection, threshold compare and pointer choice for the current node
    always_comb begin
        w_feat_k   = r_feat[r_k*DATA_W +: DATA_W];
        w_coef_k   = r_node[FW+DATA_W+2*PW-1 -: FW][r_k*DATA_W +: DATA_W];
        w_prod_ext = mul_ext(w_feat_k, w_coef_k);
        w_thr_ext  = {{(ACC_W-DATA_W){r_node[2*PW+DATA_W-1]}}, r_node[2*PW +: DATA_W]};
        w_left     = r_node[PW +: PW];
        w_right    = r_node[0 +: PW];
        w_sel      = (r_acc < w_thr_ext) ? w_left : w_right;
        w_cnt_nxt  = r_cnt + 8'd1;
    end

    // Node memory write port; writes are locked out during a traversal and during reset
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && !r_busy) begin
            r_mem[cfg_addr] <= {cfg_coef, cfg_thr, cfg_child};
        end
    end

    // Synchronous node read; the address is stable from FETCH through CMP
    always_ff @(posedge clk) begin
        r_node <= r_mem[r_addr];
    end

    // Traversal controller: IDLE -> FETCH -> MAC x N_FEAT -> CMP -> (FETCH | DONE)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_class     <= '0;
            r_path_len  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_addr      <= '0;
            r_res_err   <= 1'b0;
            r_res_class <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_feat  <= feat_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_k     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_k == KW'(N_FEAT - 1)) begin
                        r_state <= S_CMP;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_CMP: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_sel[PW-1]) begin
                        r_res_class <= w_sel[ADDR_W-1:0];
                        r_res_err   <= 1'b0;
                        r_state     <= S_DONE;
                    end else if (w_cnt_nxt < 8'(MAX_DEPTH)) begin
                        r_addr  <= w_sel[ADDR_W-1:0];
                        r_acc   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_res_class <= '0;
                        r_res_err   <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_class    <= r_res_class;
                    r_err      <= r_res_err;
                    r_path_len <= r_cnt;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/obl_tree_engine.md
OBL_TREE_ENGINE -- requirements
Module: obl_tree_engine

Interface
REQ-001 Parameter N_FEAT, default 5, number of features and coefficients per node (1..16).
REQ-002 Parameter DATA_W, default 8, signed two's-complement width of features, coefficients and threshold.
REQ-003 Parameter ADDR_W, default 6, node address width; node memory depth = 2**ADDR_W.
REQ-004 Parameter MAX_DEPTH, default 16, maximum nodes visited per traversal (1..255).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  node memory write strobe.
REQ-008 cfg_addr  in  ADDR_W  node address for write.
REQ-009 cfg_coef  in  N_FEAT*DATA_W  coefficients; coefficient k at bits [k*DATA_W +: DATA_W].
REQ-010 cfg_thr  in  DATA_W  node threshold.
REQ-011 cfg_child  in  2*(ADDR_W+1)  {left_ptr, right_ptr}; pointer MSB = leaf flag; if leaf, low ADDR_W bits = class label, else next node address.
REQ-012 feat_in  in  N_FEAT*DATA_W  feature vector, packed as cfg_coef.
REQ-013 start  in  1  traversal request.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 class_out  out  ADDR_W  result label.
REQ-017 err  out  1  depth-limit error flag, valid with done.
REQ-018 path_len  out  8  nodes visited in the last traversal.

Function
REQ-019 Node memory SHALL be written on a clk edge with cfg_we=1 and busy=0; cfg_we while busy=1 SHALL be ignored.
REQ-020 Node memory reads SHALL be synchronous, one-cycle latency; root node SHALL be address 0.
REQ-021 FSM states SHALL be IDLE, FETCH, MAC, CMP, DONE.
REQ-022 IDLE: start=1 SHALL latch feat_in, clear accumulator and node counter, set address 0, go to FETCH; start in any other state SHALL be ignored.
REQ-023 FETCH: one cycle issuing the read, then MAC.
REQ-024 MAC: exactly N_FEAT cycles, one signed product feat[k]*coef[k] added per cycle, k = 0..N_FEAT-1.
REQ-025 Accumulator width SHALL be 2*DATA_W+clog2(N_FEAT)+1 signed; no overflow or saturation is possible.
REQ-026 CMP: if acc < sign-extended thr select left_ptr, else right_ptr (acc == thr selects right); increment node counter.
REQ-027 CMP: selected pointer leaf -> DONE with class_out=label, err=0; non-leaf with node counter < MAX_DEPTH -> FETCH at pointer address with cleared accumulator.
REQ-028 CMP: non-leaf with node counter == MAX_DEPTH -> DONE with err=1, class_out=0.
REQ-029 Per-node cost SHALL be N_FEAT+2 cycles; done SHALL assert exactly n*(N_FEAT+2)+1 cycles after the accepting edge, n = nodes visited.
REQ-030 DONE: done=1 for one cycle, busy=0 from the following cycle, return to IDLE; start during DONE ignored.
REQ-031 class_out, err, path_len SHALL update only when done=1 and hold until the next done.
REQ-032 Feature changes on feat_in after acceptance SHALL not affect the running traversal.

Reset
REQ-033 rst=1 SHALL force IDLE and set busy, done, err, class_out, path_len, accumulator and counters to 0 on the next edge, in any state.
REQ-034 rst SHALL NOT clear node memory; rst mid-traversal SHALL abort without asserting done.
REQ-035 rst SHALL have priority over start and cfg_we in the same cycle.

Verification (N_FEAT=5, DATA_W=8, ADDR_W=6, MAX_DEPTH=16)
REQ-036 Node 0: coef all 1, thr=10, left=leaf 3, right=leaf 5; features 1,2,3,4,5 (sum 15) -> done 8 cycles after start, class_out=5, err=0, path_len=1.
REQ-037 Same node, coef all 0xFF (-1), features all 10 (sum -50) -> class_out=3; features summing exactly 10 -> class_out=5.
REQ-038 Node 0 right -> node 4, node 4 left=leaf 9; path to node 4 and leaf 9 -> done 15 cycles after start, class_out=9, path_len=2.
REQ-039 Node 0 both pointers = non-leaf 0 -> done 16*7+1=113 cycles after start, err=1, class_out=0, path_len=16.
REQ-040 rst pulsed during MAC of test REQ-036 -> busy=0 next cycle, no done; rerun start -> identical REQ-036 result (memory retained).
REQ-041 start and cfg_we (node 0 overwrite) while busy -> both ignored; single done, original result; memory unchanged on readback run.
